amstrad_mem_arbiter: RTL and testbench
======================================

Name: amstrad_mem_arbiter

Overview:
- Shares the single external memory port (ROM/RAM image, 23-bit byte address) between three requesters:
  - video fetch: gate-array VRAM word reads;
  - Z80 CPU: MMU-mapped reads and writes;
  - loader DMA: ROM/disk image writes and reads from the host side.
- Sits between the motherboard memory outputs and the SDRAM controller.
- Sequences one access at a time with a fixed-latency FSM.
- Arbitrates by priority with a DMA anti-starvation boost.

Parameters:
- LAT, 2, memory read latency in cycles from mem_rd assertion to mem_dout valid (1..7).
- STARVE, 64, cycles DMA may wait before it outranks the CPU (1..255).
- AW, 23, memory address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  level request for a video word fetch.
- vid_addr  in  AW  video byte address; bit0 is ignored (word access).
- vid_data  out  16  fetched video word.
- vid_valid  out  1  one-cycle strobe: vid_data valid.
- cpu_rd  in  1  CPU memory read, held for the whole Z80 cycle.
- cpu_wr  in  1  CPU memory write, held.
- cpu_addr  in  AW  CPU byte address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read byte, held until the next CPU read completes.
- cpu_ack  out  1  one-cycle strobe: CPU access done.
- dma_req  in  1  DMA request, held until dma_ack.
- dma_we  in  1  DMA write (1) or read (0).
- dma_addr  in  AW  DMA byte address.
- dma_din  in  8  DMA write data.
- dma_dout  out  8  DMA read byte.
- dma_ack  out  1  one-cycle strobe: DMA access done.
- mem_addr  out  AW  address to memory.
- mem_rd  out  1  read strobe.
- mem_we  out  1  write strobe.
- mem_wdata  out  8  write byte.
- mem_dout  in  16  read word; low byte at the even address.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - All strobes 0; mem_addr, mem_wdata, vid_data, cpu_dout, dma_dout all 0.
  - cpu_served 0; starve counter 0.
- FSM states: IDLE -> ACC -> IDLE.
  - IDLE: evaluate requests in fixed priority, latch the owner, address and data into registers, assert mem_rd or mem_we for exactly 1 cycle, go to ACC.
  - ACC: count LAT cycles.
    - Reads: capture mem_dout on the last cycle.
    - Writes: also occupy LAT cycles.
    - On the final cycle, pulse the owner's strobe (vid_valid, cpu_ack or dma_ack) and return to IDLE.
  - One access occupies LAT+1 cycles in total.
- Priority in IDLE: vid > (dma if boosted) > cpu > dma.
  - A CPU request is eligible only when (cpu_rd|cpu_wr) & ~cpu_served.
  - cpu_served is set on cpu_ack and cleared on the first cycle with cpu_rd=cpu_wr=0. This gives exactly one access per Z80 cycle.
  - cpu_rd and cpu_wr both high: treat as a write.
- Byte select for reads: cpu_dout and dma_dout take mem_dout[15:8] if the latched addr[0]=1, else mem_dout[7:0].
- Starve counter:
  - Increments (saturating at 255) each cycle dma_req=1 and DMA is not the owner.
  - Cleared on dma_ack or when dma_req=0.
  - boosted = (count >= STARVE).
- Simultaneous events:
  - vid_req and a boosted DMA both pending: video wins; DMA goes next.
  - A new request arriving in ACC waits for IDLE. Back-to-back grants are allowed, with no bubble cycle beyond IDLE.
- Requests dropped mid-ACC: the access still completes and the strobe still pulses. The requester ignores it.
- Reset asserted in ACC: the access is abandoned immediately, no strobe is issued and all outputs return to reset values next cycle.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds output cpu_wait_cnt (16 bits): a saturating count of cycles in which a CPU request is eligible but not granted.
  - Adds input stats_clr, which zeroes the counter synchronously.
  - Reset value 0.
- Undefined: neither port nor the counter exists; behaviour is otherwise identical.

Decomposition:
- Package amstrad_arb_pkg holds:
  - owner enum: OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA;
  - state enum: ST_IDLE, ST_ACC;
  - the default LAT and STARVE constants.
- Sub-module arb_starve_timer: the saturating counter and boosted compare, parameterised by STARVE.

Test Plan:
- Single CPU read, LAT=2, cpu_addr=0x00101, mem_dout=0xBEEF -> mem_rd at cycle 1, cpu_ack at cycle 3, cpu_dout=0xBE; cpu_rd held 10 cycles -> exactly one ack.
- vid_req, cpu_wr and dma_req all asserted in the same cycle -> grant order vid, cpu, dma; vid_valid, cpu_ack and dma_ack at cycles 3, 6, 9.
- Starvation, STARVE=8: cpu_rd toggles every cycle while dma_req is held -> DMA granted no later than the first IDLE with count >= 8; then the counter is cleared.
- Reset pulsed during ACC of a DMA write -> no dma_ack; all outputs 0 next cycle; FSM in IDLE.
- cpu_rd=cpu_wr=1, cpu_din=0x5A -> a mem_we pulse with mem_wdata=0x5A; no mem_rd.
- ARB_STATS_EN with vid_req held continuously and cpu_rd held for 6 cycles -> cpu_wait_cnt matches the count of cycles the CPU request was eligible but not granted; stats_clr -> 0.

Source files
------------

// File: rtl/amstrad_arb_pkg.sv
// Shared types and defaults for the Amstrad memory arbiter.
// Owner/state enums plus default latency and starvation limits.
package amstrad_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_VID,
      OWN_CPU,
      OWN_DMA
   } owner_e;

   typedef enum logic {
      ST_IDLE,
      ST_ACC
   } state_e;

   localparam int LAT_DEF    = 2;
   localparam int STARVE_DEF = 64;
   localparam int AW_DEF     = 23;

endpackage

// File: rtl/amstrad_mem_arbiter_starve.sv
// DMA starvation timer: saturating wait counter and boost flag.
// Ports: clk, reset, dma_req, dma_own, dma_ack in; boosted out.
module arb_starve_timer
   import amstrad_arb_pkg::*;
#(
   parameter int STARVE = STARVE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic dma_req,
   input  logic dma_own,
   input  logic dma_ack,
   output logic boosted
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (!dma_req || dma_ack) begin
         count <= '0;
      end else if (!dma_own && count != 8'hFF) begin
         count <= count + 8'd1;
      end
   end

   assign boosted = (count >= 8'(STARVE));

endmodule

// File: rtl/amstrad_mem_arbiter.sv
// Shares one memory port between video, Z80 CPU and loader DMA.
// Ports: clk/reset; vid_*, cpu_*, dma_* requesters; mem_* memory
// side. Build macro ARB_STATS_EN adds stats_clr and cpu_wait_cnt.
module amstrad_mem_arbiter
   import amstrad_arb_pkg::*;
#(
   parameter int LAT    = LAT_DEF,
   parameter int STARVE = STARVE_DEF,
   parameter int AW     = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [15:0]   vid_data,
   output logic          vid_valid,
   input  logic          cpu_rd,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_din,
   output logic [7:0]    dma_dout,
   output logic          dma_ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   input  logic [15:0]   mem_dout
`ifdef ARB_STATS_EN
   ,
   input  logic          stats_clr,
   output logic [15:0]   cpu_wait_cnt
`endif
);

   state_e     state;
   owner_e     owner;
   owner_e     grant;
   logic [2:0] cnt;
   logic       is_wr;
   logic       cpu_served;
   logic       boosted;
   logic       cpu_req;
   logic       cpu_elig;
   logic       dma_elig;
   logic [7:0] rd_byte;

   assign cpu_req  = cpu_rd | cpu_wr;
   assign cpu_elig = cpu_req & ~cpu_served;
   // dma_req is still high in the ack cycle; don't grant it again
   assign dma_elig = dma_req & ~dma_ack;
   assign rd_byte  = mem_addr[0] ? mem_dout[15:8] : mem_dout[7:0];

   arb_starve_timer #(
      .STARVE(STARVE)
   ) u_starve (
      .clk    (clk),
      .reset  (reset),
      .dma_req(dma_req),
      .dma_own(owner == OWN_DMA),
      .dma_ack(dma_ack),
      .boosted(boosted)
   );

   always_comb begin
      grant = OWN_NONE;
      priority case (1'b1)
         vid_req:             grant = OWN_VID;
         dma_elig && boosted: grant = OWN_DMA;
         cpu_elig:            grant = OWN_CPU;
         dma_elig:            grant = OWN_DMA;
         default:             grant = OWN_NONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= OWN_NONE;
         cnt        <= '0;
         is_wr      <= 1'b0;
         cpu_served <= 1'b0;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         vid_data   <= '0;
         vid_valid  <= 1'b0;
         cpu_dout   <= '0;
         cpu_ack    <= 1'b0;
         dma_dout   <= '0;
         dma_ack    <= 1'b0;
      end else begin
         mem_rd    <= 1'b0;
         mem_we    <= 1'b0;
         vid_valid <= 1'b0;
         cpu_ack   <= 1'b0;
         dma_ack   <= 1'b0;
         // one access per Z80 cycle: served until the bus goes idle
         if (!cpu_req) cpu_served <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (grant != OWN_NONE) begin
                  owner <= grant;
                  state <= ST_ACC;
                  cnt   <= '0;
                  case (grant)
                     OWN_VID: begin
                        mem_addr <= vid_addr & ~AW'(1);
                        is_wr    <= 1'b0;
                        mem_rd   <= 1'b1;
                     end
                     OWN_CPU: begin
                        mem_addr  <= cpu_addr;
                        is_wr     <= cpu_wr;
                        mem_rd    <= ~cpu_wr;
                        mem_we    <= cpu_wr;
                        mem_wdata <= cpu_din;
                     end
                     OWN_DMA: begin
                        mem_addr  <= dma_addr;
                        is_wr     <= dma_we;
                        mem_rd    <= ~dma_we;
                        mem_we    <= dma_we;
                        mem_wdata <= dma_din;
                     end
                     default: ;
                  endcase
               end
            end
            ST_ACC: begin
               if (cnt == 3'(LAT - 1)) begin
                  state <= ST_IDLE;
                  owner <= OWN_NONE;
                  case (owner)
                     OWN_VID: begin
                        vid_valid <= 1'b1;
                        vid_data  <= mem_dout;
                     end
                     OWN_CPU: begin
                        cpu_ack <= 1'b1;
                        if (cpu_req) cpu_served <= 1'b1;
                        if (!is_wr) cpu_dout <= rd_byte;
                     end
                     OWN_DMA: begin
                        dma_ack <= 1'b1;
                        if (!is_wr) dma_dout <= rd_byte;
                     end
                     default: ;
                  endcase
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
         endcase
      end
   end

`ifdef ARB_STATS_EN
   // waiting excludes the CPU's own grant and access cycles
   logic cpu_wait;
   assign cpu_wait = cpu_elig && owner != OWN_CPU &&
                     !(state == ST_IDLE && grant == OWN_CPU);

   always_ff @(posedge clk) begin
      if (reset || stats_clr) begin
         cpu_wait_cnt <= '0;
      end else if (cpu_wait && cpu_wait_cnt != 16'hFFFF) begin
         cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Bench for amstrad_mem_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-schedule model.
module tb_amstrad_mem_arbiter;

   localparam int LAT    = 2;
   localparam int STARVE = 8;
   localparam int AW     = 23;
   localparam int NMAX   = 4096;

   logic          clk = 1'b0;
   logic          reset;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [15:0]   vid_data;
   logic          vid_valid;
   logic          cpu_rd;
   logic          cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din;
   logic [7:0]    cpu_dout;
   logic          cpu_ack;
   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [7:0]    dma_din;
   logic [7:0]    dma_dout;
   logic          dma_ack;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [15:0]   mem_dout;
`ifdef ARB_STATS_EN
   logic          stats_clr;
   logic [15:0]   cpu_wait_cnt;
   int            m_wait;
`endif

   always #5 clk = ~clk;

   amstrad_mem_arbiter #(
      .LAT(LAT), .STARVE(STARVE), .AW(AW)
   ) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_data(vid_data), .vid_valid(vid_valid),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we),
      .dma_addr(dma_addr), .dma_din(dma_din),
      .dma_dout(dma_dout), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_dout(mem_dout)
`ifdef ARB_STATS_EN
      , .stats_clr(stats_clr),
      .cpu_wait_cnt(cpu_wait_cnt)
`endif
   );

   int compared   = 0;
   int mismatched = 0;
   int n = 0;

   // expected-event schedule, indexed by cycle number
   bit            e_rd[NMAX], e_we[NMAX], e_rst[NMAX];
   bit            e_vv[NMAX], e_ca[NMAX], e_da[NMAX];
   bit            e_cds[NMAX], e_dds[NMAX];
   bit [AW-1:0]   e_addr[NMAX];
   bit [7:0]      e_wd[NMAX], e_cd[NMAX], e_dd[NMAX];
   bit [15:0]     e_vd[NMAX];
   bit            rd_hist[NMAX];
   bit [AW-1:0]   ad_hist[NMAX];

   int       free_at = 0;
   int       cg = -100;
   int       dg = -100;
   bit       served = 0;
   int       starve = 0;
   bit [7:0] hv_cd = 0;
   bit       ovr_en = 0;
   bit [15:0] ovr_val = 0;

   function automatic bit [15:0] mem_word(input bit [AW-1:0] a);
      if (ovr_en) return ovr_val;
      return {a[8:1] ^ 8'h3C, a[16:9] + a[8:1]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, n, act, exp);
      end
   endtask

   task automatic clr_slot(input int i);
      e_rd[i] = 0; e_we[i] = 0; e_rst[i] = 0;
      e_vv[i] = 0; e_ca[i] = 0; e_da[i] = 0;
      e_cds[i] = 0; e_dds[i] = 0;
   endtask

   // decide what cycle n's inputs lead to, from the rules alone
   task automatic model_cycle();
      int who;
      bit creq, cok, dok, dack, down, cown, wr;
      bit [AW-1:0] a;
      bit [7:0] wd, b;
      bit [15:0] w;
      if (reset) begin
         for (int i = n + 1; i <= n + LAT + 3; i++) clr_slot(i);
         e_rst[n+1] = 1;
         free_at = n + 1;
         cg = -100; dg = -100;
         served = 0; starve = 0;
`ifdef ARB_STATS_EN
         m_wait = 0;
`endif
         return;
      end
      dack = e_da[n];
      down = (n > dg) && (n <= dg + LAT);
      cown = (n > cg) && (n <= cg + LAT);
      creq = cpu_rd | cpu_wr;
      cok  = creq && !served;
      dok  = dma_req && !dack;
      who  = 0;
      if (n >= free_at) begin
         if (vid_req) who = 1;
         else if (dok && starve >= STARVE) who = 3;
         else if (cok) who = 2;
         else if (dok) who = 3;
      end
      if (who != 0) begin
         wd = 0;
         if (who == 1) begin
            a = vid_addr; a[0] = 1'b0; wr = 0;
         end else if (who == 2) begin
            a = cpu_addr; wr = cpu_wr; wd = cpu_din; cg = n;
         end else begin
            a = dma_addr; wr = dma_we; wd = dma_din; dg = n;
         end
         free_at = n + 1 + LAT;
         e_addr[n+1] = a;
         e_rd[n+1] = !wr;
         e_we[n+1] = wr;
         e_wd[n+1] = wd;
         w = mem_word(a);
         b = a[0] ? w[15:8] : w[7:0];
         if (who == 1) begin
            e_vv[free_at] = 1; e_vd[free_at] = w;
         end else if (who == 2) begin
            e_ca[free_at] = 1;
            if (!wr) begin e_cds[free_at] = 1; e_cd[free_at] = b; end
         end else begin
            e_da[free_at] = 1;
            if (!wr) begin e_dds[free_at] = 1; e_dd[free_at] = b; end
         end
      end
`ifdef ARB_STATS_EN
      if (stats_clr) m_wait = 0;
      else if (cok && !cown && who != 2 && m_wait < 65535) m_wait++;
`endif
      served = creq ? (served || e_ca[n+1]) : 1'b0;
      if (!dma_req || dack) starve = 0;
      else if (!down && starve < 255) starve++;
   endtask

   task automatic compare_cycle();
      if (e_rst[n]) hv_cd = 0;
      if (e_cds[n]) hv_cd = e_cd[n];
      chk("mem_rd", mem_rd, e_rd[n]);
      chk("mem_we", mem_we, e_we[n]);
      if (e_rd[n] || e_we[n]) chk("mem_addr", mem_addr, e_addr[n]);
      if (e_we[n]) chk("mem_wdata", mem_wdata, e_wd[n]);
      chk("vid_valid", vid_valid, e_vv[n]);
      if (e_vv[n]) chk("vid_data", vid_data, e_vd[n]);
      chk("cpu_ack", cpu_ack, e_ca[n]);
      chk("cpu_dout", cpu_dout, hv_cd);
      chk("dma_ack", dma_ack, e_da[n]);
      if (e_dds[n]) chk("dma_dout", dma_dout, e_dd[n]);
`ifdef ARB_STATS_EN
      chk("cpu_wait_cnt", cpu_wait_cnt, m_wait);
`endif
   endtask

   // memory: word for a read is presented LAT-1 cycles after mem_rd
   task automatic drive_mem();
      int k;
      rd_hist[n] = (mem_rd === 1'b1);
      ad_hist[n] = mem_addr;
      k = n - (LAT - 1);
      if (k >= 0 && rd_hist[k]) mem_dout = mem_word(ad_hist[k]);
      else mem_dout = 16'($urandom);
   endtask

   task automatic tick();
      model_cycle();
      @(posedge clk);
      #1;
      n++;
      compare_cycle();
      drive_mem();
   endtask

   task automatic idle(input int k);
      vid_req = 0; cpu_rd = 0; cpu_wr = 0; dma_req = 0;
      repeat (k) tick();
   endtask

   int n0, rr, vv, ca, da, acks, rd_at;
   int cpu_left = 0;
   bit dack_d = 0;

   initial begin
      reset = 1; vid_req = 0; vid_addr = 0;
      cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_din = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_din = 0;
      mem_dout = 0;
`ifdef ARB_STATS_EN
      stats_clr = 0; m_wait = 0;
`endif
      repeat (3) tick();
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_vid_data", vid_data, 0);
      chk("rst_dma_dout", dma_dout, 0);
      reset = 0;
      idle(2);

      // single CPU read, held 10 cycles
      ovr_en = 1; ovr_val = 16'hBEEF;
      n0 = n; rd_at = -1; ca = -1; acks = 0;
      cpu_addr = 23'h00101;
      for (int r = 0; r < 10; r++) begin
         cpu_rd = 1;
         tick();
         rr = n - n0;
         if (mem_rd && rd_at < 0) rd_at = rr;
         if (cpu_ack) begin acks++; if (ca < 0) ca = rr; end
      end
      chk("t1_rd_cycle", rd_at, 1);
      chk("t1_ack_cycle", ca, 3);
      chk("t1_ack_count", acks, 1);
      chk("t1_cpu_dout", cpu_dout, 8'hBE);
      idle(5);
      ovr_en = 0;

      // vid, cpu write and dma write arrive together
      n0 = n; vv = -1; ca = -1; da = -1;
      vid_req = 1; vid_addr = 23'h000ABD;
      cpu_wr = 1; cpu_addr = 23'h00321; cpu_din = 8'h11;
      dma_req = 1; dma_we = 1; dma_addr = 23'h40000;
      dma_din = 8'h22;
      for (int r = 0; r < 12; r++) begin
         if (r >= 1) vid_req = 0;
         if (ca >= 0 && r > ca) cpu_wr = 0;
         if (da >= 0 && r > da) dma_req = 0;
         tick();
         rr = n - n0;
         if (vid_valid && vv < 0) vv = rr;
         if (cpu_ack && ca < 0) ca = rr;
         if (dma_ack && da < 0) da = rr;
      end
      chk("t2_vid_valid_cycle", vv, 3);
      chk("t2_cpu_ack_cycle", ca, 6);
      chk("t2_dma_ack_cycle", da, 9);
      idle(5);

      // DMA starved by a CPU that re-arms in every IDLE
      n0 = n; da = -1; acks = 0;
      dma_req = 1; dma_we = 0; dma_addr = 23'h00445;
      cpu_addr = 23'h00200;
      for (int r = 0; r < 16; r++) begin
         cpu_rd = (r % 3 != 2) && (r < 15);
         if (da >= 0 && r > da) dma_req = 0;
         tick();
         rr = n - n0;
         if (cpu_ack && rr <= 12) acks++;
         if (dma_ack && da < 0) da = rr;
      end
      chk("t3_dma_ack_cycle", da, 12);
      chk("t3_cpu_acks_before", acks, 3);
      idle(5);

      // reset during the ACC of a DMA write
      n0 = n; acks = 0;
      dma_req = 1; dma_we = 1; dma_addr = 23'h12345;
      dma_din = 8'h33;
      tick();
      chk("t4_mem_we", mem_we, 1);
      reset = 1;
      tick();
      chk("t4_mem_we0", mem_we, 0);
      chk("t4_mem_rd0", mem_rd, 0);
      chk("t4_mem_addr0", mem_addr, 0);
      chk("t4_mem_wdata0", mem_wdata, 0);
      chk("t4_dma_ack0", dma_ack, 0);
      chk("t4_cpu_dout0", cpu_dout, 0);
      chk("t4_vid_data0", vid_data, 0);
      reset = 0; dma_req = 0;
      for (int r = 0; r < 5; r++) begin
         tick();
         if (dma_ack) acks++;
      end
      chk("t4_no_dma_ack", acks, 0);

      // read and write together counts as a write
      n0 = n;
      cpu_addr = 23'h00077; cpu_din = 8'h5A;
      for (int r = 0; r < 6; r++) begin
         cpu_rd = (r < 4); cpu_wr = (r < 4);
         tick();
         if (n - n0 == 1) begin
            chk("t5_mem_we", mem_we, 1);
            chk("t5_mem_rd", mem_rd, 0);
            chk("t5_mem_wdata", mem_wdata, 8'h5A);
         end
      end
      idle(4);

`ifdef ARB_STATS_EN
      stats_clr = 1;
      tick();
      stats_clr = 0;
      vid_addr = 23'h00010;
      for (int r = 0; r < 8; r++) begin
         vid_req = 1;
         cpu_rd = (r < 6);
         tick();
         if (r == 5) chk("t6_wait_cnt", cpu_wait_cnt, 6);
      end
      stats_clr = 1;
      tick();
      chk("t6_wait_clr", cpu_wait_cnt, 0);
      stats_clr = 0;
      idle(5);
`endif

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom % 500 == 0);
         if ($urandom % 8 == 0) vid_req = ~vid_req;
         vid_addr = AW'($urandom);
         if (cpu_left > 0) begin
            cpu_left--;
         end else if (cpu_rd | cpu_wr) begin
            cpu_rd = 0; cpu_wr = 0;
         end else if ($urandom % 3 == 0) begin
            rr = $urandom % 8;
            cpu_rd = (rr < 5); cpu_wr = (rr >= 4);
            cpu_addr = AW'($urandom);
            cpu_din = 8'($urandom);
            cpu_left = $urandom_range(1, 10);
         end
         if (dma_req && dack_d) begin
            dma_req = 0;
         end else if (!dma_req && $urandom % 4 == 0) begin
            dma_req = 1;
            dma_we = 1'($urandom);
            dma_addr = AW'($urandom);
            dma_din = 8'($urandom);
         end
`ifdef ARB_STATS_EN
         stats_clr = ($urandom % 64 == 0);
`endif
         dack_d = dma_ack;
         tick();
      end
      reset = 0;
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
